axi4_lite_slave: RTL and testbench
==================================

// Module: axi4_lite_slave
// PURPOSE
//  AXI4-Lite slave register bank with 2**addr_width 32-bit registers and byte-strobed writes.
//  Write address and write data are accepted independently, in either order.
//  Reads return register contents.
//  Sits behind an AXI4-Lite interconnect as a CSR block.
// PARAMETERS
//  addr_width  3   register index width; awaddr/araddr are word indices, not byte addresses
//  data_width  32  register/data bus width
//  strb_width  4   write strobe width (data_width/8)
//  num_regs    8   implemented registers, indices 0..num_regs-1; must be <= 2**addr_width
// PORTS
//  aclk     in   1           clock; all logic on rising edge
//  aresetn  in   1           asynchronous active-low reset
//  awaddr   in   addr_width  write register index
//  awprot   in   3           ignored (a 1-bit driver zero-extends)
//  awvalid  in   1           write address valid
//  awready  out  1           write address ready
//  wdata    in   data_width  write data
//  wstrb    in   strb_width  byte enables; bit i covers wdata[8i+7:8i]
//  wvalid   in   1           write data valid
//  wready   out  1           write data ready
//  bresp    out  2           write response
//  bvalid   out  1           write response valid
//  bready   in   1           write response ready
//  araddr   in   addr_width  read register index
//  arprot   in   3           ignored
//  arvalid  in   1           read address valid
//  arready  out  1           read address ready
//  rdata    out  data_width  read data
//  rresp    out  2           read response
//  rvalid   out  1           read data valid
//  rready   in   1           read data ready
// BEHAVIOUR
//  - One clock (aclk); reset is asynchronous and active-low (aresetn).
//  - Reset values:
//    - registers, bvalid, rvalid, bresp, rresp, rdata = 0
//    - internal aw_full/w_full = 0
//    - awready/wready/arready = 1
//  - Ready signals are combinational:
//    - awready = !aw_full && !bvalid
//    - wready  = !w_full  && !bvalid
//    - arready = !rvalid
//  - AW handshake (awvalid&&awready at an edge): latch awaddr and set aw_full.
//  - W handshake: latch wdata/wstrb and set w_full.
//  - AW and W handshakes may occur in the same cycle or either one first, any gap allowed.
//  - Edge after aw_full&&w_full:
//    - update reg[addr]: bytes with strobe=1 take new data, bytes with strobe=0 keep old value
//    - set bvalid=1 and bresp=2'b00; clear aw_full/w_full
//  - Latency: simultaneous AW+W handshake at edge N -> register write and bvalid=1 at edge N+1.
//  - bvalid stays high with bresp stable until bready; cleared at the edge where bvalid&&bready.
//  - No new AW/W accepted while bvalid=1.
//  - Valid held high after its handshake is not re-accepted until the buffer empties.
//  - AR handshake at edge N: rdata=reg[araddr], rresp=2'b00, rvalid=1 at edge N.
//  - rvalid/rdata/rresp are held until rvalid&&rready, then rvalid=0.
//  - Read and write channels are independent.
//  - A read captured on the same edge as a write to the same register returns the pre-write value.
//  - Reset mid-transaction: latched AW/W are discarded, bvalid/rvalid drop immediately, registers clear.
// CONFIGURATION
//  AXI4L_SLVERR_EN:
//   defined -> index >= num_regs: write dropped, bresp=2'b10; read returns rdata=0, rresp=2'b10.
//   undefined -> same accesses: write dropped, read returns 0, both responses 2'b00.
// TESTING
//  - AW idx1 one cycle before W data=100 strb=1111, bready after -> bvalid then bresp=00; read idx1 -> 100.
//  - W data=200 strb=1111 one cycle before AW idx2 -> single bvalid; read idx2 -> 200.
//  - Write idx3 0x12345678 strb=1111, then 0x9999AAAA strb=1010 -> read idx3 = 0x9934AA78.
//  - Hold bready=0 for 5 cycles after write -> bvalid stays 1, awready=wready=0.
//  - Hold rready=0 for 5 cycles after read -> rvalid/rdata stable, arready=0.
//  - aresetn low while AW latched with no W -> awready=1, no write occurs, all registers read 0.
//  - With AXI4L_SLVERR_EN and num_regs=6, write idx7 -> bresp=10; read idx7 -> rresp=10, rdata=0.

Source files
------------

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite CSR register bank: independent AW/W capture, byte-strobed writes, single-beat reads.
// Optional macro AXI4L_SLVERR_EN: out-of-range indices answer SLVERR (2'b10) instead of OKAY.
module axi4_lite_slave #(
  parameter int unsigned addr_width = 3,
  parameter int unsigned data_width = 32,
  parameter int unsigned strb_width = 4,
  parameter int unsigned num_regs   = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [addr_width-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [data_width-1:0] wdata,
  input  logic [strb_width-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [addr_width-1:0] araddr,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [data_width-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  logic [data_width-1:0] regs [num_regs];

  logic                  aw_full;
  logic                  w_full;
  logic [addr_width-1:0] aw_addr;
  logic [data_width-1:0] w_data;
  logic [strb_width-1:0] w_strb;

  logic       aw_hs;
  logic       w_hs;
  logic       ar_hs;
  logic       aw_in_range;
  logic       ar_in_range;
  logic [1:0] oor_resp;
  logic       unused_prot;

`ifdef AXI4L_SLVERR_EN
  assign oor_resp = 2'b10;
`else
  assign oor_resp = 2'b00;
`endif

  assign unused_prot = ^{awprot, arprot};

  assign awready = !aw_full && !bvalid;
  assign wready  = !w_full && !bvalid;
  assign arready = !rvalid;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  assign aw_in_range = 32'(aw_addr) < num_regs;
  assign ar_in_range = 32'(araddr) < num_regs;

  // Commit happens one edge after both halves are buffered; bvalid is never high
  // while either buffer is full, so the commit and bready paths cannot collide.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < num_regs; i++) regs[i] <= '0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
    end else if (aw_full && w_full) begin
      if (aw_in_range) begin
        for (int unsigned i = 0; i < strb_width; i++) begin
          if (w_strb[i]) regs[aw_addr][8*i +: 8] <= w_data[8*i +: 8];
        end
      end
      bvalid  <= 1'b1;
      bresp   <= aw_in_range ? 2'b00 : oor_resp;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_addr <= awaddr;
        aw_full <= 1'b1;
      end
      if (w_hs) begin
        w_data <= wdata;
        w_strb <= wstrb;
        w_full <= 1'b1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= ar_in_range ? regs[araddr] : '0;
      rresp  <= ar_in_range ? 2'b00 : oor_resp;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Bench for axi4_lite_slave (num_regs=6 so indices 6,7 are out of range), table vectors,
// directed corner sequences and random traffic against an array-based register model.
module tb_axi4_lite_slave;

  localparam int unsigned NREGS = 6;
`ifdef AXI4L_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [2:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [2:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  always #5 aclk = ~aclk;

  axi4_lite_slave #(
    .addr_width(3),
    .data_width(32),
    .strb_width(4),
    .num_regs(NREGS)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int unsigned total = 0;
  int unsigned passed = 0;
  logic [31:0] model [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] idx);
    return (32'(idx) < NREGS) ? model[idx] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [2:0] idx);
    return (32'(idx) < NREGS) ? 2'b00 : OOR_RESP;
  endfunction

  task automatic model_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
    if (32'(idx) < NREGS) model[idx] = merge(model[idx], d, s);
  endtask

  // Entered and left at posedge+1.
  task automatic do_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s,
                          input int unsigned aw_dly, input int unsigned w_dly,
                          output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    bit got = 0;
    int unsigned cyc = 0;
    resp = 2'b11;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && cyc >= aw_dly;
      awaddr  = idx;
      wvalid  = !w_done && cyc >= w_dly;
      wdata   = d;
      wstrb   = s;
      @(negedge aclk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge aclk); #1;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("write_handshake_done", 32'(aw_done && w_done), 32'd1);
    bready = 1'b1;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge aclk);
      if (bvalid) begin
        got = 1;
        resp = bresp;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    bready = 1'b0;
    check("bvalid_seen", 32'(got), 32'd1);
    check("bvalid_cleared", 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [2:0] idx, output logic [31:0] data, output logic [1:0] resp);
    bit got = 0;
    int unsigned cyc = 0;
    arvalid = 1'b1;
    araddr  = idx;
    while (!got && cyc < 20) begin
      @(negedge aclk);
      if (arready) got = 1;
      @(posedge aclk); #1;
      cyc++;
    end
    arvalid = 1'b0;
    check("ar_handshake_done", 32'(got), 32'd1);
    check("rvalid_after_ar", 32'(rvalid), 32'd1);
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    check("rvalid_cleared", 32'(rvalid), 32'd0);
  endtask

  task automatic reset_pulse();
    #2 aresetn = 1'b0;
    @(posedge aclk); #3;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rsp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic [31:0] old_v;

    tbl[0] = '{3'd0, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 2'b00};
    tbl[1] = '{3'd0, 32'h11223344, 4'b0001, 32'hDEADBE44, 2'b00};
    tbl[2] = '{3'd0, 32'h55667788, 4'b1000, 32'h55ADBE44, 2'b00};
    tbl[3] = '{3'd4, 32'hCAFEF00D, 4'b0110, 32'h00FEF000, 2'b00};
    tbl[4] = '{3'd5, 32'hFFFFFFFF, 4'b0000, 32'h00000000, 2'b00};
    tbl[5] = '{3'd5, 32'hA5A5A5A5, 4'b0101, 32'h00A500A5, 2'b00};
    tbl[6] = '{3'd6, 32'h12345678, 4'b1111, 32'h00000000, OOR_RESP};
    tbl[7] = '{3'd7, 32'h9999AAAA, 4'b1111, 32'h00000000, OOR_RESP};
    for (int i = 0; i < 8; i++) model[i] = '0;

    // Reset state, sampled while reset is held.
    #12;
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready",  32'(wready),  32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    check("rst_rdata",   rdata,        32'd0);
    #10 aresetn = 1'b1;
    @(posedge aclk); #1;

    for (int i = 0; i < 8; i++) begin
      do_write(tbl[i].idx, tbl[i].data, tbl[i].strb, 32'(i % 3), 32'((i + 1) % 3), r);
      check("tbl_bresp", 32'(r), 32'(tbl[i].exp_rsp));
      model_write(tbl[i].idx, tbl[i].data, tbl[i].strb);
      do_read(tbl[i].idx, d, r);
      check("tbl_rdata", d, tbl[i].exp_rd);
      check("tbl_rresp", 32'(r), 32'(tbl[i].exp_rsp));
    end

    // AW one cycle ahead of W.
    do_write(3'd1, 32'd100, 4'b1111, 0, 1, r);
    check("aw_first_bresp", 32'(r), 32'd0);
    model_write(3'd1, 32'd100, 4'b1111);
    do_read(3'd1, d, r);
    check("aw_first_rdata", d, 32'd100);

    // W one cycle ahead of AW, then no second response.
    do_write(3'd2, 32'd200, 4'b1111, 1, 0, r);
    model_write(3'd2, 32'd200, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      check("single_bvalid", 32'(bvalid), 32'd0);
    end
    do_read(3'd2, d, r);
    check("w_first_rdata", d, 32'd200);

    // Partial strobe merge.
    do_write(3'd3, 32'h12345678, 4'b1111, 0, 0, r);
    do_write(3'd3, 32'h9999AAAA, 4'b1010, 0, 0, r);
    model_write(3'd3, 32'h12345678, 4'b1111);
    model_write(3'd3, 32'h9999AAAA, 4'b1010);
    do_read(3'd3, d, r);
    check("strb_merge", d, 32'h9934AA78);

    // Latency plus backpressure on B: offered AW/W must not be taken while bvalid is high.
    awvalid = 1'b1; awaddr = 3'd2; wvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'b1111;
    @(posedge aclk); #1;
    check("lat_bvalid_n", 32'(bvalid), 32'd0);
    awaddr = 3'd4; wdata = 32'h77777777;
    @(posedge aclk); #1;
    check("lat_bvalid_n1", 32'(bvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_bvalid",  32'(bvalid),  32'd1);
      check("hold_bresp",   32'(bresp),   32'd0);
      check("hold_awready", 32'(awready), 32'd0);
      check("hold_wready",  32'(wready),  32'd0);
      @(posedge aclk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("hold_bvalid_drop", 32'(bvalid), 32'd0);
    model_write(3'd2, 32'h0BADF00D, 4'b1111);
    do_read(3'd4, d, r);
    check("blocked_write_dropped", d, exp_read(3'd4));
    do_read(3'd2, d, r);
    check("lat_write_rdata", d, 32'h0BADF00D);

    // Backpressure on R.
    arvalid = 1'b1; araddr = 3'd3;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      araddr = 3'($urandom_range(0, 7));
      check("rhold_rvalid",  32'(rvalid),  32'd1);
      check("rhold_rdata",   rdata,        32'h9934AA78);
      check("rhold_arready", 32'(arready), 32'd0);
      @(posedge aclk); #1;
    end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    check("rhold_drop", 32'(rvalid), 32'd0);

    // Read captured on the same edge as a write to the same register.
    old_v = model[0];
    awvalid = 1'b1; awaddr = 3'd0; wvalid = 1'b1; wdata = 32'hFEEDFACE; wstrb = 4'b1111;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 3'd0;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("same_edge_bvalid", 32'(bvalid), 32'd1);
    check("same_edge_rvalid", 32'(rvalid), 32'd1);
    check("same_edge_old",    rdata,       old_v);
    bready = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;
    model_write(3'd0, 32'hFEEDFACE, 4'b1111);
    do_read(3'd0, d, r);
    check("same_edge_new", d, 32'hFEEDFACE);

    // Reset with AW latched (no W) and a read response pending.
    awvalid = 1'b1; awaddr = 3'd4; arvalid = 1'b1; araddr = 3'd0;
    @(posedge aclk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    check("pre_rst_awready", 32'(awready), 32'd0);
    check("pre_rst_rvalid",  32'(rvalid),  32'd1);
    #2 aresetn = 1'b0;
    #1;
    check("async_rst_awready", 32'(awready), 32'd1);
    check("async_rst_rvalid",  32'(rvalid),  32'd0);
    check("async_rst_bvalid",  32'(bvalid),  32'd0);
    @(posedge aclk); #3 aresetn = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b1; wdata = 32'h5A5A5A5A; wstrb = 4'b1111;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("no_write_bvalid", 32'(bvalid), 32'd0);
      @(posedge aclk); #1;
    end
    reset_pulse();
    for (int i = 0; i < 8; i++) begin
      do_read(3'(i), d, r);
      check("post_rst_zero", d, 32'd0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  idx;
      logic [31:0] wd;
      logic [3:0]  ws;
      idx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        ws = 4'($urandom_range(0, 15));
        do_write(idx, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), r);
        check("rnd_bresp", 32'(r), 32'(exp_resp(idx)));
        model_write(idx, wd, ws);
      end else begin
        do_read(idx, d, r);
        check("rnd_rdata", d, exp_read(idx));
        check("rnd_rresp", 32'(r), 32'(exp_resp(idx)));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
